// File: rtl/vend_txn_scheduler.sv
// vend_txn_scheduler: sole master of the cash handler. Arbitrates customer and
// maintenance requests, runs purchases as debit-then-credit with a customer
// refund on failure, and keeps a shadow machine balance for range pre-checks.
// Optional build macro: VTS_TIMEOUT_EN enables the wait-state watchdog.
module vend_txn_scheduler #(
    parameter int unsigned AMT_W   = 4,
    parameter int unsigned MAX_BAL = 15,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cust_req,
    input  logic             cust_func,
    input  logic [AMT_W-1:0] cust_amount,
    output logic             cust_ack,
    output logic             cust_ok,
    input  logic             mnt_req,
    input  logic             mnt_func,
    input  logic [AMT_W-1:0] mnt_amount,
    output logic             mnt_ack,
    output logic             mnt_ok,
    output logic             ch_start,
    output logic             ch_mode,
    output logic             ch_func,
    output logic [AMT_W-1:0] ch_amount,
    input  logic             ch_done,
    input  logic             ch_res,
    output logic [AMT_W-1:0] mach_bal,
    output logic             busy,
    output logic             fault,
    output logic             timeout_err
);
    localparam int unsigned      SUM_W     = AMT_W + 1;
    localparam logic [SUM_W-1:0] MAX_BAL_S = SUM_W'(MAX_BAL);

    typedef enum logic [2:0] {
        IDLE, DEBIT, W_DEBIT, CREDIT, W_CREDIT, RBACK, W_RBACK, RESP
    } state_t;

    typedef struct packed {
        logic             mode;
        logic             func;
        logic [AMT_W-1:0] amount;
    } ch_op_t;

    state_t           state, state_d;
    logic             own_mnt, own_mnt_d;     // 1: current transaction belongs to maintenance
    logic             txn_func, txn_func_d;
    logic [AMT_W-1:0] txn_amt, txn_amt_d;
    logic             rr_last, rr_last_d;     // 1: maintenance was granted last
    logic [AMT_W-1:0] bal_d;
    logic             ok_d, fault_d, tmo_d;
    logic             grant_mnt, charge_d;
    ch_op_t           op_d;
    logic             is_purchase, is_charge;
    logic [SUM_W-1:0] bal_plus_txn, bal_plus_mnt;
    logic             wait_expired;

    assign is_purchase  = !own_mnt && !txn_func;
    assign is_charge    = !own_mnt && txn_func;
    assign bal_plus_txn = SUM_W'(mach_bal) + SUM_W'(txn_amt);
    assign bal_plus_mnt = SUM_W'(mach_bal) + SUM_W'(mnt_amount);

`ifdef VTS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             in_wait;

    assign in_wait      = (state == W_DEBIT) || (state == W_CREDIT) || (state == W_RBACK);
    assign wait_expired = in_wait && !ch_done && (wait_cnt == CNT_W'(TIMEOUT - 1));

    // Watchdog: cycles spent in the current wait state, cleared on every state change
    always_ff @(posedge clock) begin
        if (reset || (state_d != state)) begin
            wait_cnt <= '0;
        end else if (in_wait) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`else
    assign wait_expired = 1'b0;
`endif

    // State register plus latched transaction context, shadow balance and sticky fault
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            own_mnt  <= 1'b0;
            txn_func <= 1'b0;
            txn_amt  <= '0;
            rr_last  <= 1'b1;
            mach_bal <= '0;
            fault    <= 1'b0;
        end else begin
            state    <= state_d;
            own_mnt  <= own_mnt_d;
            txn_func <= txn_func_d;
            txn_amt  <= txn_amt_d;
            rr_last  <= rr_last_d;
            mach_bal <= bal_d;
            fault    <= fault_d;
        end
    end

    // Next-state, arbitration, balance update and handler op selection
    always_comb begin
        state_d    = state;
        own_mnt_d  = own_mnt;
        txn_func_d = txn_func;
        txn_amt_d  = txn_amt;
        rr_last_d  = rr_last;
        bal_d      = mach_bal;
        ok_d       = 1'b0;
        fault_d    = fault;
        tmo_d      = 1'b0;
        grant_mnt  = 1'b0;
        charge_d   = 1'b0;
        op_d       = '{mode: ch_mode, func: ch_func, amount: ch_amount};

        case (state)
            IDLE: begin
                if (cust_req || mnt_req) begin
                    grant_mnt  = mnt_req && (!cust_req || !rr_last);
                    rr_last_d  = grant_mnt;
                    own_mnt_d  = grant_mnt;
                    txn_func_d = grant_mnt ? mnt_func : cust_func;
                    txn_amt_d  = grant_mnt ? mnt_amount : cust_amount;
                    if (!grant_mnt) begin
                        state_d = cust_func ? CREDIT : DEBIT;
                    end else if (!mnt_func) begin
                        state_d = (bal_plus_mnt > MAX_BAL_S) ? RESP : CREDIT;
                    end else begin
                        state_d = (mnt_amount > mach_bal) ? RESP : DEBIT;
                    end
                end
            end
            DEBIT:  state_d = W_DEBIT;
            CREDIT: state_d = W_CREDIT;
            RBACK:  state_d = W_RBACK;
            W_DEBIT: begin
                if (ch_done) begin
                    if (!ch_res) begin
                        state_d = RESP;
                    end else if (own_mnt) begin
                        bal_d   = mach_bal - txn_amt;
                        ok_d    = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = (bal_plus_txn > MAX_BAL_S) ? RBACK : CREDIT;
                    end
                end
            end
            W_CREDIT: begin
                if (ch_done) begin
                    if (ch_res) begin
                        ok_d    = 1'b1;
                        state_d = RESP;
                        if (!is_charge) begin
                            bal_d = mach_bal + txn_amt;
                        end
                    end else begin
                        state_d = is_purchase ? RBACK : RESP;
                    end
                end
            end
            W_RBACK: begin
                if (ch_done) begin
                    if (!ch_res) begin
                        fault_d = 1'b1;
                    end
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Watchdog abort overrides the wait state (only reachable without ch_done)
        if (wait_expired) begin
            tmo_d   = 1'b1;
            ok_d    = 1'b0;
            state_d = RESP;
            if (state == W_RBACK) begin
                fault_d = 1'b1;
            end
        end

        charge_d = !own_mnt_d && txn_func_d;
        case (state_d)
            DEBIT:   op_d = '{own_mnt_d, own_mnt_d, txn_amt_d};
            CREDIT:  op_d = '{!charge_d, charge_d, txn_amt_d};
            RBACK:   op_d = '{1'b0, 1'b1, txn_amt_d};
            default: ;
        endcase
    end

    // Registered outputs decoded from the next state
    always_ff @(posedge clock) begin
        if (reset) begin
            ch_start    <= 1'b0;
            ch_mode     <= 1'b0;
            ch_func     <= 1'b0;
            ch_amount   <= '0;
            cust_ack    <= 1'b0;
            cust_ok     <= 1'b0;
            mnt_ack     <= 1'b0;
            mnt_ok      <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            ch_start    <= (state_d == DEBIT) || (state_d == CREDIT) || (state_d == RBACK);
            {ch_mode, ch_func, ch_amount} <= op_d;
            cust_ack    <= (state_d == RESP) && !own_mnt_d;
            cust_ok     <= (state_d == RESP) && !own_mnt_d && ok_d;
            mnt_ack     <= (state_d == RESP) && own_mnt_d;
            mnt_ok      <= (state_d == RESP) && own_mnt_d && ok_d;
            busy        <= (state_d != IDLE);
            timeout_err <= tmo_d;
        end
    end

endmodule

// File: tb/tb_vend_txn_scheduler.sv
// Testbench for vend_txn_scheduler: directed and random request mixes checked
// against a transaction-level model; a behavioural cash handler answers each
// op after a random delay with a forced or random result.
module tb_vend_txn_scheduler;
    localparam int unsigned AMT_W = 4;
`ifdef VTS_TIMEOUT_EN
    localparam int unsigned TMO = 8;
`else
    localparam int unsigned TMO = 255;
`endif

    logic             clock;
    logic             reset;
    logic             cust_req, cust_func, cust_ack, cust_ok;
    logic [AMT_W-1:0] cust_amount;
    logic             mnt_req, mnt_func, mnt_ack, mnt_ok;
    logic [AMT_W-1:0] mnt_amount;
    logic             ch_start, ch_mode, ch_func, ch_done, ch_res;
    logic [AMT_W-1:0] ch_amount;
    logic [AMT_W-1:0] mach_bal;
    logic             busy, fault, timeout_err;

    int errors = 0;
    int checks = 0;

    // Behavioural handler state and op/result logs
    int op_q[$];
    bit res_q[$];
    bit forced_q[$];
    bit hs_busy = 1'b0;
    bit hs_hold = 1'b0;
    bit hs_res  = 1'b0;
    int hs_cnt  = 0;

    // Reference model state
    int m_bal   = 0;
    bit m_fault = 1'b0;
    bit rr_m    = 1'b1;   // 1: maintenance served last

    vend_txn_scheduler #(.AMT_W(AMT_W), .MAX_BAL(15), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .cust_req(cust_req), .cust_func(cust_func), .cust_amount(cust_amount),
        .cust_ack(cust_ack), .cust_ok(cust_ok),
        .mnt_req(mnt_req), .mnt_func(mnt_func), .mnt_amount(mnt_amount),
        .mnt_ack(mnt_ack), .mnt_ok(mnt_ok),
        .ch_start(ch_start), .ch_mode(ch_mode), .ch_func(ch_func), .ch_amount(ch_amount),
        .ch_done(ch_done), .ch_res(ch_res),
        .mach_bal(mach_bal), .busy(busy), .fault(fault), .timeout_err(timeout_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int enc(input bit m, input bit f, input int a);
        return m * 32 + f * 16 + a;
    endfunction

    // Cash handler: logs each op, answers after 0..3 extra cycles
    initial begin
        ch_done = 1'b0;
        ch_res  = 1'b0;
        forever begin
            @(posedge clock); #1;
            ch_done = 1'b0;
            ch_res  = 1'b0;
            if (hs_busy && !hs_hold) begin
                if (hs_cnt == 0) begin
                    ch_done = 1'b1;
                    ch_res  = hs_res;
                    hs_busy = 1'b0;
                end else begin
                    hs_cnt--;
                end
            end
            if (ch_start) begin
                op_q.push_back(enc(ch_mode, ch_func, int'(ch_amount)));
                hs_res = (forced_q.size() > 0) ? forced_q.pop_front() : ($urandom_range(0, 3) != 0);
                res_q.push_back(hs_res);
                hs_busy = 1'b1;
                hs_cnt  = $urandom_range(0, 3);
            end
        end
    end

    // Transaction-level model: expected ops, result, balance and fault from the handler results
    task automatic model_check(input bit mnt, input bit fn, input int a, input bit ok_obs);
        int exp_ops[$];
        bit ok;
        bit r0, r1, r2;
        r0 = (res_q.size() > 0) ? res_q[0] : 1'b0;
        r1 = (res_q.size() > 1) ? res_q[1] : 1'b0;
        r2 = (res_q.size() > 2) ? res_q[2] : 1'b0;
        ok = 1'b0;
        if (!mnt && !fn) begin
            exp_ops.push_back(enc(0, 0, a));
            if (r0) begin
                if (m_bal + a > 15) begin
                    exp_ops.push_back(enc(0, 1, a));
                    if (!r1) m_fault = 1'b1;
                end else begin
                    exp_ops.push_back(enc(1, 0, a));
                    if (r1) begin
                        ok = 1'b1;
                        m_bal += a;
                    end else begin
                        exp_ops.push_back(enc(0, 1, a));
                        if (!r2) m_fault = 1'b1;
                    end
                end
            end
        end else if (!mnt) begin
            exp_ops.push_back(enc(0, 1, a));
            ok = r0;
        end else if (!fn) begin
            if (m_bal + a <= 15) begin
                exp_ops.push_back(enc(1, 0, a));
                ok = r0;
                if (ok) m_bal += a;
            end
        end else begin
            if (a <= m_bal) begin
                exp_ops.push_back(enc(1, 1, a));
                ok = r0;
                if (ok) m_bal -= a;
            end
        end
        check_eq(mnt ? "mnt_op_count" : "cust_op_count", op_q.size(), exp_ops.size());
        for (int i = 0; i < exp_ops.size() && i < op_q.size(); i++)
            check_eq($sformatf("op%0d_mode_func_amt", i), op_q[i], exp_ops[i]);
        check_eq(mnt ? "mnt_ok" : "cust_ok", int'(ok_obs), int'(ok));
        check_eq("mach_bal", int'(mach_bal), m_bal);
        check_eq("fault", int'(fault), int'(m_fault));
        op_q.delete();
        res_q.delete();
    endtask

    // sel: 0 customer only, 1 maintenance only, 2 both raised together
    task automatic run_txn(input int sel, input bit cf, input int ca, input bit mf, input int ma);
        bit cp, mp;
        int exp_first_mnt;
        cp = (sel != 1);
        mp = (sel != 0);
        exp_first_mnt = rr_m ? 0 : 1;
        check_eq("idle_busy", int'(busy), 0);
        cust_func   = cf;
        cust_amount = AMT_W'(ca);
        mnt_func    = mf;
        mnt_amount  = AMT_W'(ma);
        cust_req    = cp;
        mnt_req     = mp;
        for (int cyc = 0; cyc < 400 && (cp || mp); cyc++) begin
            @(posedge clock); #1;
            if (!cp) check_eq("cust_ack_extra", int'(cust_ack), 0);
            if (!mp) check_eq("mnt_ack_extra", int'(mnt_ack), 0);
            if (cp && mp && (cust_ack || mnt_ack))
                check_eq("arb_first_is_mnt", int'(mnt_ack), exp_first_mnt);
            if (cp && cust_ack) begin
                cp = 1'b0;
                cust_req = 1'b0;
                rr_m = 1'b0;
                model_check(1'b0, cf, ca, cust_ok);
            end
            if (mp && mnt_ack) begin
                mp = 1'b0;
                mnt_req = 1'b0;
                rr_m = 1'b1;
                model_check(1'b1, mf, ma, mnt_ok);
            end
        end
        check_eq("ack_wait_pending", int'(cp) + int'(mp), 0);
        cust_req = 1'b0;
        mnt_req  = 1'b0;
        @(posedge clock); #1;
        check_eq("ack_one_cycle", int'(cust_ack) + int'(mnt_ack), 0);
        op_q.delete();
        res_q.delete();
    endtask

    initial begin
        bit seen;
        int n;
        reset = 1'b1;
        cust_req = 1'b0; cust_func = 1'b0; cust_amount = '0;
        mnt_req = 1'b0;  mnt_func = 1'b0;  mnt_amount = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_fault", int'(fault), 0);
        check_eq("rst_mach_bal", int'(mach_bal), 0);
        check_eq("rst_acks", int'(cust_ack) + int'(mnt_ack), 0);
        check_eq("rst_ch_start", int'(ch_start), 0);
        check_eq("rst_timeout_err", int'(timeout_err), 0);

        forced_q = '{1'b1, 1'b1};                 run_txn(0, 1'b0, 3, 1'b0, 0);   // purchase 3 -> bal 3
        forced_q = '{1'b0};                       run_txn(0, 1'b0, 5, 1'b0, 0);   // debit fails
        forced_q = '{1'b1};                       run_txn(1, 1'b0, 0, 1'b0, 11);  // deposit -> bal 14
        forced_q = '{1'b1, 1'b1};                 run_txn(0, 1'b0, 2, 1'b0, 0);   // overflow -> rollback
        run_txn(1, 1'b0, 0, 1'b1, 15);                                            // withdraw > bal rejected
        run_txn(1, 1'b0, 0, 1'b0, 2);                                             // deposit overflow rejected
        forced_q = '{1'b1, 1'b1};                 run_txn(2, 1'b1, 4, 1'b1, 3);   // tie: cust then mnt
        forced_q = '{1'b1, 1'b1};                 run_txn(2, 1'b1, 2, 1'b1, 1);   // tie again
        forced_q = '{1'b1, 1'b0, 1'b0};           run_txn(0, 1'b0, 2, 1'b0, 0);   // failed refund -> fault
        forced_q.delete();

        for (int t = 0; t < 150; t++)
            run_txn($urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                    1'($urandom_range(0, 1)), $urandom_range(0, 15));

`ifdef VTS_TIMEOUT_EN
        hs_hold = 1'b1;
        cust_func = 1'b1; cust_amount = AMT_W'(5); cust_req = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clock); #1;
            if (ch_start) seen = 1'b1;
        end
        check_eq("tmo_start_seen", int'(seen), 1);
        n = 0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(posedge clock); #1;
            n++;
            if (timeout_err) seen = 1'b1;
        end
        check_eq("tmo_wait_cycles", n - 1, TMO);
        check_eq("tmo_cust_ack", int'(cust_ack), 1);
        check_eq("tmo_cust_ok", int'(cust_ok), 0);
        cust_req = 1'b0;
        @(posedge clock); #1;
        check_eq("tmo_pulse_len", int'(timeout_err), 0);
        op_q.delete();
        res_q.delete();
`endif

        // Reset while waiting on a credit; the handler answers late after reset
        hs_hold = 1'b1;
        cust_func = 1'b1; cust_amount = AMT_W'(7); cust_req = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clock); #1;
            if (ch_start) seen = 1'b1;
        end
        check_eq("mid_start_seen", int'(seen), 1);
        @(posedge clock); #1;
        check_eq("mid_busy_before", int'(busy), 1);
        reset = 1'b1;
        cust_req = 1'b0;
        @(posedge clock); #1;
        check_eq("mid_rst_busy", int'(busy), 0);
        check_eq("mid_rst_ch_bus", int'(ch_mode) + int'(ch_func) + int'(ch_amount), 0);
        check_eq("mid_rst_mach_bal", int'(mach_bal), 0);
        check_eq("mid_rst_fault", int'(fault), 0);
        reset = 1'b0;
        hs_hold = 1'b0;
        m_bal = 0; m_fault = 1'b0; rr_m = 1'b1;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock); #1;
            n += int'(busy) + int'(ch_start) + int'(cust_ack) + int'(mnt_ack);
        end
        check_eq("late_done_ignored", n, 0);
        op_q.delete();
        res_q.delete();
        forced_q = '{1'b1};
        run_txn(1, 1'b0, 0, 1'b0, 6);   // post-reset deposit from a zero balance

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
